// File: rtl/soc_run_ctrl_if.sv
// Interface bundling the run-request side and the SoC-facing side of soc_run_ctrl.
// master = harness/bench driving requests and SoC flags, slave = the controller.
interface soc_run_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             start_i;
  logic             sel_req_i;
  logic             abort_i;
  logic             over_i;
  logic             succ_i;
  logic             soc_rst_n_o;
  logic             chip_sel_o;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;
  logic             timeout_o;
  logic [CNT_W-1:0] cycles_o;

  modport master (
    output start_i, sel_req_i, abort_i, over_i, succ_i,
    input  soc_rst_n_o, chip_sel_o, busy_o, done_o, pass_o, timeout_o, cycles_o
  );

  modport slave (
    input  start_i, sel_req_i, abort_i, over_i, succ_i,
    output soc_rst_n_o, chip_sel_o, busy_o, done_o, pass_o, timeout_o, cycles_o
  );
endinterface

// File: rtl/soc_run_ctrl.sv
// Run controller: holds the SoC in reset, releases it, watches over/succ and reports
// pass, fail or timeout together with the number of cycles the SoC ran.
module soc_run_ctrl #(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000,
  parameter int unsigned CNT_W           = 32
) (
  input logic          clk,
  input logic          rst,
  soc_run_ctrl_if.slave bus
);

  localparam int unsigned HoldMax = (RST_HOLD_CYCLES > SETTLE_CYCLES) ? RST_HOLD_CYCLES
                                                                      : SETTLE_CYCLES;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);

  localparam logic [HoldW-1:0] RstLast    = HoldW'(RST_HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] SettleLast = HoldW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StReset, StSettle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             soc_rst_n_q, soc_rst_n_d;
  logic             chip_sel_q, chip_sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic [CNT_W-1:0] cycles_inc;
  logic             timeout_hit;

  // Saturating increment; the timeout test looks at the value this edge would store.
  assign cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
  assign timeout_hit = 64'(cycles_inc) >= 64'(TIMEOUT_CYCLES);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    soc_rst_n_d = soc_rst_n_q;
    chip_sel_d  = chip_sel_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    cycles_d    = cycles_q;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start_i) begin
          chip_sel_d = bus.sel_req_i;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          cycles_d   = '0;
          busy_d     = 1'b1;
          hold_d     = '0;
          state_d    = StReset;
        end
      end
      StReset: begin
        if (bus.abort_i) begin
          busy_d  = 1'b0;
          done_d  = 1'b0;
          state_d = StIdle;
        end else if (hold_q == RstLast) begin
          hold_d      = '0;
          soc_rst_n_d = 1'b1;
          state_d     = StSettle;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StSettle: begin
        // over_i is deliberately ignored here: the SoC flags read 1 straight out of reset.
        if (bus.abort_i) begin
          soc_rst_n_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b0;
          state_d     = StIdle;
        end else begin
          cycles_d = cycles_inc;
          if (hold_q == SettleLast) begin
            state_d = StRun;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
      end
      StRun: begin
        if (bus.abort_i) begin
          soc_rst_n_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b0;
          state_d     = StIdle;
        end else begin
          cycles_d = cycles_inc;
          if (bus.over_i) begin
            pass_d      = bus.succ_i;
            timeout_d   = 1'b0;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            soc_rst_n_d = 1'b0;
            state_d     = StDone;
          end else if (timeout_hit) begin
            pass_d      = 1'b0;
            timeout_d   = 1'b1;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            soc_rst_n_d = 1'b0;
            state_d     = StDone;
          end
        end
      end
      default: begin
        soc_rst_n_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      soc_rst_n_q <= 1'b0;
      chip_sel_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      soc_rst_n_q <= soc_rst_n_d;
      chip_sel_q  <= chip_sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      cycles_q    <= cycles_d;
    end
  end

  assign bus.soc_rst_n_o = soc_rst_n_q;
  assign bus.chip_sel_o  = chip_sel_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.pass_o      = pass_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.cycles_o    = cycles_q;

endmodule

// File: tb/tb_soc_run_ctrl.sv
// Bench for soc_run_ctrl: a driver pushes each run's expected outcome into a scoreboard,
// a negedge monitor pops and compares when busy_o drops.
module tb_soc_run_ctrl;
  localparam int unsigned RST_HOLD = 16;
  localparam int unsigned SETTLE   = 2;
  localparam int unsigned TIMEOUT  = 120;
  localparam int unsigned CNT_W    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  soc_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  soc_run_ctrl #(
    .RST_HOLD_CYCLES(RST_HOLD),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          sel;
    bit          aborted;
    bit          pass;
    bit          tmo;
    int unsigned cycles;
    int unsigned end_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: hold length, chip_sel stability, run start and run end against the scoreboard.
  bit          prev_busy = 1'b0;
  bit          prev_rstn = 1'b0;
  bit          prev_sel  = 1'b0;
  int unsigned low_cnt   = 0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      low_cnt   = 0;
      prev_busy = 1'b0;
      prev_rstn = 1'b0;
    end else begin
      if (bus.busy_o && !bus.soc_rst_n_o) low_cnt++;
      if (bus.busy_o && bus.soc_rst_n_o && !prev_rstn) begin
        check("rst_hold_len", low_cnt, RST_HOLD);
        low_cnt = 0;
      end
      if (!bus.busy_o) low_cnt = 0;
      if (prev_rstn && bus.soc_rst_n_o) check("chip_sel_stable", bus.chip_sel_o, prev_sel);
      if (!prev_busy && bus.busy_o) begin
        if (sb.size() == 0) check("unexpected_start", 1, 0);
        else begin
          check("start_chip_sel", bus.chip_sel_o, sb[0].sel);
          check("start_done_clr", bus.done_o, 0);
          check("start_cycles_clr", bus.cycles_o, 0);
        end
      end
      if (prev_busy && !bus.busy_o) begin
        if (sb.size() == 0) check("unexpected_end", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("end_cycle", cyc, mon_e.end_cyc);
          check("end_done", bus.done_o, !mon_e.aborted);
          check("end_soc_rst_n", bus.soc_rst_n_o, 0);
          check("end_chip_sel", bus.chip_sel_o, mon_e.sel);
          if (!mon_e.aborted) begin
            check("end_pass", bus.pass_o, mon_e.pass);
            check("end_timeout", bus.timeout_o, mon_e.tmo);
            check("end_cycles", bus.cycles_o, mon_e.cycles);
          end
        end
      end
      prev_busy = bus.busy_o;
      prev_rstn = bus.soc_rst_n_o;
      prev_sel  = bus.chip_sel_o;
    end
  end

  task automatic idle_inputs();
    bus.start_i   = 1'b0;
    bus.abort_i   = 1'b0;
    bus.over_i    = 1'b0;
    bus.succ_i    = 1'b0;
    bus.sel_req_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    check("rst_soc_rst_n", bus.soc_rst_n_o, 0);
    check("rst_chip_sel", bus.chip_sel_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_pass", bus.pass_o, 0);
    check("rst_timeout", bus.timeout_o, 0);
    check("rst_cycles", bus.cycles_o, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // h: first high cycle with over_i=1, then held (0 = never).
  // abt / st_t: cycle after start carrying abort_i / a stray start_i (0 = none).
  task automatic run(input bit sel, input bit succ, input int unsigned h,
                     input int unsigned abt, input int unsigned st_t);
    exp_t        e;
    int unsigned fin;
    int unsigned last_t;
    fin = (h == 0) ? TIMEOUT + 1 : ((h <= SETTLE) ? SETTLE + 1 : h);
    if (fin > TIMEOUT) begin
      e.tmo = 1'b1; e.pass = 1'b0; e.cycles = TIMEOUT; fin = TIMEOUT;
    end else begin
      e.tmo = 1'b0; e.pass = succ; e.cycles = fin;
    end
    last_t    = RST_HOLD + fin;
    e.aborted = (abt != 0) && (abt <= last_t);
    if (e.aborted) last_t = abt;
    e.sel = sel;
    bus.start_i   = 1'b1;
    bus.sel_req_i = sel;
    @(posedge clk);
    #1;
    e.end_cyc = cyc + last_t;
    sb.push_back(e);
    for (int unsigned t = 1; t <= last_t; t++) begin
      bus.abort_i   = (t == abt);
      bus.start_i   = (t == st_t);
      bus.sel_req_i = 1'($urandom_range(0, 1));
      bus.over_i    = (h != 0) && (t > RST_HOLD) && (t - RST_HOLD >= h);
      bus.succ_i    = bus.over_i ? succ : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    idle_inputs();
    repeat (2 + $urandom_range(0, 3)) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned h, abt, st_t;
    idle_inputs();
    do_reset();

    run(1'b1, 1'b1, SETTLE + 100, 0, 0);            // pass, cycles 102
    run(1'b0, 1'b0, SETTLE + 100, 0, 0);            // fail
    run(1'b1, 1'b1, 0, 0, 0);                       // timeout
    run(1'b0, 1'b1, 1, 0, 0);                       // over held through settle
    run(1'b1, 1'b1, TIMEOUT, 0, 0);                 // over collides with timeout
    run(1'b1, 1'b1, 60, 0, RST_HOLD + 30);          // stray start mid-run
    run(1'b0, 1'b1, 80, RST_HOLD + 40, 0);          // abort mid-run
    run(1'b1, 1'b0, 50, 5, 5);                      // abort and start together in reset

    // rst during RESET, then a fresh run with the select flipped
    bus.start_i   = 1'b1;
    bus.sel_req_i = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back('{sel: 1'b0, aborted: 1'b1, pass: 1'b0, tmo: 1'b0, cycles: 0, end_cyc: 0});
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    run(1'b1, 1'b1, 30, 0, 0);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       h = $urandom_range(1, SETTLE);
        1:       h = $urandom_range(SETTLE + 1, TIMEOUT);
        2:       h = $urandom_range(TIMEOUT + 1, TIMEOUT + 20);
        default: h = 0;
      endcase
      abt  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, RST_HOLD + SETTLE + 1) : 0;
      st_t = ($urandom_range(0, 2) == 0) ? $urandom_range(1, RST_HOLD + SETTLE + 1) : 0;
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), h, abt, st_t);
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
